// File: rtl/ptmch_spi_rx.sv
// rtl/ptmch_spi_rx.sv - SPI mode-0 ADDR+DATA frame receiver with valid/ready write port
// Optional trailing even-parity bit enabled by defining PTMCH_SPI_PARITY_EN.
`timescale 1ns/1ps

module ptmch_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16
) (
  input  logic              CLK160M,
  input  logic              RESET,
  input  logic              SPI_CS,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  output logic              WR_VALID,
  input  logic              WR_READY,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              FRM_ERR,
  output logic              OVF_ERR,
  output logic              BUSY
);

`ifdef PTMCH_SPI_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = ADDR_W + DATA_W + PAR_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam int FL_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FL_W-1:0] FL_MAX = FL_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, clk_sync, mosi_sync;
  logic                   cs_q, clk_q;
  logic [FL_W-1:0]        flush_cnt;
  logic                   armed;
  logic                   cs_s, clk_s, mosi_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt, cnt_next;
  logic [FRAME_BITS-1:0]   shreg, sh_next;
  logic                    parity_ok;

  // The CS preset would look like a falling edge if CS is already low when
  // RESET drops; armed blocks that until CS has genuinely been seen high.
  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      cs_sync   <= '1;
      clk_sync  <= '0;
      mosi_sync <= '0;
      cs_q      <= 1'b1;
      clk_q     <= 1'b0;
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], SPI_CLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      cs_q      <= cs_s;
      clk_q     <= clk_s;
      if (flush_cnt != FL_MAX)
        flush_cnt <= flush_cnt + 1'b1;
      else if (cs_s)
        armed <= 1'b1;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = clk_s & ~clk_q;
  assign cs_fall   = armed & cs_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_q;

  // A bit arriving with cs_rise is shifted before the count is judged.
  always_comb begin
    cnt_next = bit_cnt;
    sh_next  = shreg;
    if (sclk_rise) begin
      sh_next = {shreg[FRAME_BITS-2:0], mosi_s};
      if (bit_cnt != CNT_SAT)
        cnt_next = bit_cnt + 1'b1;
    end
  end

`ifdef PTMCH_SPI_PARITY_EN
  assign parity_ok = ~^shreg;
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      WR_VALID <= 1'b0;
      WR_ADDR  <= '0;
      WR_DATA  <= '0;
      FRM_ERR  <= 1'b0;
      OVF_ERR  <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      FRM_ERR <= 1'b0;
      OVF_ERR <= 1'b0;
      if (WR_VALID && WR_READY)
        WR_VALID <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state   <= S_SHIFT;
            bit_cnt <= '0;
            BUSY    <= 1'b1;
          end
        end
        S_SHIFT: begin
          bit_cnt <= cnt_next;
          shreg   <= sh_next;
          if (cs_rise) begin
            if (cnt_next == CNT_FULL) begin
              state <= S_CHECK;
            end else begin
              FRM_ERR <= 1'b1;
              state   <= S_IDLE;
              BUSY    <= 1'b0;
            end
          end
        end
        S_CHECK: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          if (!parity_ok) begin
            FRM_ERR <= 1'b1;
          end else if (WR_VALID && !WR_READY) begin
            OVF_ERR <= 1'b1;
          end else begin
            WR_ADDR  <= shreg[FRAME_BITS-1 -: ADDR_W];
            WR_DATA  <= shreg[PAR_BITS +: DATA_W];
            WR_VALID <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
